// File: rtl/lc3b_types.sv
// Shared lc3b pipeline types: stage occupancy encoding and the canonical bubble
// control value used to squash a stage's control bundle.
package lc3b_types;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_occ_t;

   // Wide enough for any stage's control bundle; stages take the low CTRL_W bits.
   localparam int unsigned PIPE_CTRL_MAX_W = 64;
   localparam logic [PIPE_CTRL_MAX_W-1:0] PIPE_CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones,
// clears on synchronous active-low reset.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: increment unless already saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and 2-entry skid buffer.
// Optional stall/bubble counters when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
   import lc3b_types::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned CTRL_W = 24,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              flush,
`ifdef PIPE_STAGE_PERF_EN
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt,
`endif
   output logic [1:0]        occupancy
);

   localparam logic [CTRL_W-1:0] CTRL_BUBBLE = PIPE_CTRL_BUBBLE[CTRL_W-1:0];

   pipe_occ_t         state_q, state_d;
   logic [WIDTH-1:0]  main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [WIDTH-1:0]  skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              in_fire, out_fire;

   // Handshake signals decode from the state register only, so neither
   // out_ready nor in_* reach any output combinationally.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign occupancy = state_q;
   assign out_data  = main_data_q;
   assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Next-state and storage update; flush overrides every transition.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               state_d     = ONE;
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else begin
               state_d = EMPTY;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else if (in_fire) begin
               state_d     = FULL;
               skid_data_d = in_data;
               skid_ctrl_d = in_ctrl;
            end else if (out_fire) begin
               state_d = EMPTY;
            end else begin
               state_d = ONE;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_d     = ONE;
               main_data_d = skid_data_q;
               main_ctrl_d = skid_ctrl_q;
            end else begin
               state_d = FULL;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      // Squashed entries keep their data but lose control so they cannot act.
      if (flush) begin
         state_d     = EMPTY;
         main_data_d = main_data_q;
         main_ctrl_d = CTRL_BUBBLE;
         skid_data_d = skid_data_q;
         skid_ctrl_d = CTRL_BUBBLE;
      end else begin
         state_d = state_d;
      end
   end

   // State and storage registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (out_valid & ~out_ready),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~out_valid & out_ready),
      .count (bubble_cnt)
   );
`else
   // Counter width only matters with the counters built in.
   if (CNT_W == 0) begin : g_no_cnt
   end
`endif

endmodule
